// File: rtl/tdp_text_ram_pkg.sv
// tdp_text_ram_pkg: types and constants shared by tdp_text_ram and its clear sequencer.
// Contents: clear-FSM state encoding and the port-A read-during-write mode selectors.
// No logic lives here.
package tdp_text_ram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_t;

  localparam int READ_FIRST  = 0;
  localparam int WRITE_FIRST = 1;

endpackage

// File: rtl/text_ram_clr_fsm.sv
// text_ram_clr_fsm: sequencer that walks every RAM address once, issuing fill writes.
// Ports: clk/reset (sync, active-high), clr_start request in; wr_en/wr_addr write
//        command out, busy (CLEAR or DONE) and a one-cycle done pulse out.
module text_ram_clr_fsm
  import tdp_text_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr_start,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  clr_state_t            state;
  clr_state_t            next_state;
  logic [ADDR_WIDTH-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && clr_start) begin
        cnt <= '0;
      end else if (state == CLEAR && cnt != LAST_ADDR) begin
        // Counter parks on the last address so it never starts a second pass.
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    next_state = state;
    wr_en      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        // clr_start is only looked at here, so requests while busy are ignored.
        if (clr_start) next_state = CLEAR;
      end
      CLEAR: begin
        wr_en = 1'b1;
        busy  = 1'b1;
        if (cnt == LAST_ADDR) next_state = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign wr_addr = cnt;

endmodule

// File: rtl/tdp_text_ram.sv
// tdp_text_ram: text-mode RAM, port A read/byte-write, port B (video) read-only, with a
//   fill engine. Ports: clk, reset; port A we_a/be_a/addr_a/din_a/dout_a; port B
//   addr_b/dout_b; clr_start/clr_busy/clr_done; collision (B read the word A wrote).
module tdp_text_ram
  import tdp_text_ram_pkg::*;
#(
  parameter int                  ADDR_WIDTH = 12,
  parameter int                  DATA_WIDTH = 16,
  parameter int                  RDW_MODE   = 0,
  parameter int                  OUT_REG    = 0,
  parameter logic [DATA_WIDTH-1:0] FILL_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    we_a,
  input  logic [DATA_WIDTH/8-1:0] be_a,
  input  logic [ADDR_WIDTH-1:0]   addr_a,
  input  logic [DATA_WIDTH-1:0]   din_a,
  output logic [DATA_WIDTH-1:0]   dout_a,
  input  logic [ADDR_WIDTH-1:0]   addr_b,
  output logic [DATA_WIDTH-1:0]   dout_b,
  input  logic                    clr_start,
  output logic                    clr_busy,
  output logic                    clr_done,
  output logic                    collision
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;

  logic                  wr_en;
  logic [LANES-1:0]      wr_be;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] merged_a;
  logic [DATA_WIDTH-1:0] b_q;

  text_ram_clr_fsm #(.ADDR_WIDTH(ADDR_WIDTH)) u_clr (
    .clk       (clk),
    .reset     (reset),
    .clr_start (clr_start),
    .wr_en     (clr_we),
    .wr_addr   (clr_addr),
    .busy      (clr_busy),
    .done      (clr_done)
  );

  // Single write port: the clear engine owns it while busy; user writes are dropped
  // for the whole busy window, and nothing is written in a reset cycle.
  always_comb begin
    wr_en   = ~reset & (clr_we | (we_a & ~clr_busy));
    wr_be   = clr_we ? {LANES{1'b1}} : be_a;
    wr_addr = clr_we ? clr_addr : addr_a;
    wr_data = clr_we ? FILL_VALUE : din_a;
  end

  // Storage has no reset so reset never disturbs contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < LANES; i++) begin
        if (wr_be[i]) mem[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
      end
    end
  end

  // Write-first view of port A: old word with this cycle's enabled lanes overlaid.
  always_comb begin
    merged_a = mem[addr_a];
    if (wr_en && wr_addr == addr_a) begin
      for (int i = 0; i < LANES; i++) begin
        if (wr_be[i]) merged_a[i*8 +: 8] = wr_data[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dout_a    <= '0;
      b_q       <= '0;
      collision <= 1'b0;
    end else begin
      dout_a    <= (RDW_MODE == WRITE_FIRST) ? merged_a : mem[addr_a];
      b_q       <= mem[addr_b];  // port B is always read-first
      collision <= wr_en && (|wr_be) && (wr_addr == addr_b);
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] b_q2;
      always_ff @(posedge clk) begin
        if (reset) b_q2 <= '0;
        else       b_q2 <= b_q;
      end
      assign dout_b = b_q2;
    end else begin : g_no_out_reg
      assign dout_b = b_q;
    end
  endgenerate

endmodule

// File: tb/tb_tdp_text_ram.sv
module tb_tdp_text_ram;

  logic        clk = 1'b0;
  logic        reset;
  logic        we_a;
  logic [1:0]  be_a;
  logic [3:0]  addr_a;
  logic [15:0] din_a;
  logic [3:0]  addr_b;
  logic        clr_start;

  logic [15:0] dout_a0, dout_b0, dout_a1, dout_b1;
  logic        busy0, done0, coll0, busy1, done1, coll1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Instance 0: read-first, no output register.
  tdp_text_ram #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .RDW_MODE(0), .OUT_REG(0),
                 .FILL_VALUE(16'h0720)) u_dut0 (
    .clk(clk), .reset(reset), .we_a(we_a), .be_a(be_a), .addr_a(addr_a),
    .din_a(din_a), .dout_a(dout_a0), .addr_b(addr_b), .dout_b(dout_b0),
    .clr_start(clr_start), .clr_busy(busy0), .clr_done(done0), .collision(coll0));

  // Instance 1: write-first, extra port-B output register.
  tdp_text_ram #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .RDW_MODE(1), .OUT_REG(1),
                 .FILL_VALUE(16'h0720)) u_dut1 (
    .clk(clk), .reset(reset), .we_a(we_a), .be_a(be_a), .addr_a(addr_a),
    .din_a(din_a), .dout_a(dout_a1), .addr_b(addr_b), .dout_b(dout_b1),
    .clr_start(clr_start), .clr_busy(busy1), .clr_done(done1), .collision(coll1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    if ({dout_a0, dout_b0, dout_a1, dout_b1} !== 64'h0) begin
      failures++; $display("FAIL reset_douts got=%h exp=0", {dout_a0, dout_b0, dout_a1, dout_b1});
    end
    checks++;
    if ({busy0, done0, coll0, busy1, done1, coll1} !== 6'b0) begin
      failures++; $display("FAIL reset_flags got=%b exp=000000", {busy0, done0, coll0, busy1, done1, coll1});
    end
    checks++;
    reset = 1'b0;
  endtask

  task automatic test_clear();
    int busy_cnt = 0;
    int done_cnt = 0;
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (busy0) busy_cnt++;
      if (done0) done_cnt++;
      if (busy0 !== busy1 || done0 !== done1) begin
        failures++; $display("FAIL clear_flags_agree cycle=%0d got=%b%b exp=%b%b", i, busy1, done1, busy0, done0);
      end
      checks++;
      // Hammer word 3 with user writes while busy; re-trigger mid-clear.
      we_a      = busy0;
      addr_a    = 4'd3;
      din_a     = 16'hFFFF;
      be_a      = 2'b11;
      clr_start = (i == 5);
      tick();
    end
    we_a = 1'b0;
    clr_start = 1'b0;
    if (busy_cnt !== 17) begin
      failures++; $display("FAIL clear_busy_len got=%0d exp=17", busy_cnt);
    end
    checks++;
    if (done_cnt !== 1) begin
      failures++; $display("FAIL clear_done_pulses got=%0d exp=1", done_cnt);
    end
    checks++;
    for (int i = 0; i < 16; i++) begin
      addr_a = 4'(i);
      addr_b = 4'(i);
      tick();
      if (dout_a0 !== 16'h0720 || dout_b0 !== 16'h0720 || dout_a1 !== 16'h0720) begin
        failures++; $display("FAIL clear_word%0d got=%h/%h/%h exp=0720", i, dout_a0, dout_b0, dout_a1);
      end
      checks++;
      tick();
      if (dout_b1 !== 16'h0720) begin
        failures++; $display("FAIL clear_word%0d_b_reg got=%h exp=0720", i, dout_b1);
      end
      checks++;
    end
  endtask

  task automatic test_byte_enable();
    we_a = 1'b1; addr_a = 4'd5; din_a = 16'h1234; be_a = 2'b11;
    tick();
    din_a = 16'hABCD; be_a = 2'b10;
    tick();
    if (dout_a0 !== 16'h1234 || dout_a1 !== 16'hAB34) begin
      failures++; $display("FAIL be_same_cycle got=%h/%h exp=1234/ab34", dout_a0, dout_a1);
    end
    checks++;
    we_a = 1'b0;
    tick();
    if (dout_a0 !== 16'hAB34 || dout_a1 !== 16'hAB34) begin
      failures++; $display("FAIL be_merge got=%h/%h exp=ab34", dout_a0, dout_a1);
    end
    checks++;
    we_a = 1'b1; din_a = 16'h5555; be_a = 2'b00;
    tick();
    we_a = 1'b0;
    tick();
    if (dout_a0 !== 16'hAB34 || dout_a1 !== 16'hAB34) begin
      failures++; $display("FAIL be_zero_noop got=%h/%h exp=ab34", dout_a0, dout_a1);
    end
    checks++;
  endtask

  task automatic test_rdw();
    we_a = 1'b1; addr_a = 4'd7; din_a = 16'h1111; be_a = 2'b11;
    tick();
    din_a = 16'h2222;
    tick();
    if (dout_a0 !== 16'h1111) begin
      failures++; $display("FAIL rdw_read_first got=%h exp=1111", dout_a0);
    end
    checks++;
    if (dout_a1 !== 16'h2222) begin
      failures++; $display("FAIL rdw_write_first got=%h exp=2222", dout_a1);
    end
    checks++;
    we_a = 1'b0;
    tick();
    if (dout_a0 !== 16'h2222 || dout_a1 !== 16'h2222) begin
      failures++; $display("FAIL rdw_next_read got=%h/%h exp=2222", dout_a0, dout_a1);
    end
    checks++;
  endtask

  task automatic test_collision();
    addr_b = 4'd9; we_a = 1'b0;
    tick();
    tick();
    we_a = 1'b1; addr_a = 4'd9; din_a = 16'h00FF; be_a = 2'b11;
    tick();
    if (coll0 !== 1'b1 || coll1 !== 1'b1) begin
      failures++; $display("FAIL coll_assert got=%b%b exp=11", coll0, coll1);
    end
    checks++;
    if (dout_b0 !== 16'h0720) begin
      failures++; $display("FAIL coll_old_b_lat1 got=%h exp=0720", dout_b0);
    end
    checks++;
    we_a = 1'b0;
    tick();
    if (coll0 !== 1'b0 || coll1 !== 1'b0) begin
      failures++; $display("FAIL coll_pulse got=%b%b exp=00", coll0, coll1);
    end
    checks++;
    if (dout_b0 !== 16'h00FF || dout_b1 !== 16'h0720) begin
      failures++; $display("FAIL coll_b_next got=%h/%h exp=00ff/0720", dout_b0, dout_b1);
    end
    checks++;
    tick();
    if (dout_b1 !== 16'h00FF) begin
      failures++; $display("FAIL coll_b_reg_new got=%h exp=00ff", dout_b1);
    end
    checks++;
    we_a = 1'b1; be_a = 2'b00;
    tick();
    we_a = 1'b0;
    if (coll0 !== 1'b0) begin
      failures++; $display("FAIL coll_be_zero got=%b exp=0", coll0);
    end
    checks++;
  endtask

  task automatic test_abort();
    logic [15:0] exp_w [16];
    int done_cnt = 0;
    // Mark words 0-4 so the partial clear is visible.
    for (int i = 0; i < 5; i++) begin
      we_a = 1'b1; addr_a = 4'(i); din_a = 16'hBEEF; be_a = 2'b11;
      tick();
    end
    we_a = 1'b0;
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (done0 || done1) done_cnt++;
      tick();
    end
    // Reset wins over a same-cycle user write and clear request.
    reset = 1'b1; clr_start = 1'b1;
    we_a = 1'b1; addr_a = 4'd12; din_a = 16'h0001; be_a = 2'b11;
    tick();
    if ({dout_a0, dout_b0, dout_a1, dout_b1} !== 64'h0 ||
        {busy0, done0, coll0, busy1, done1, coll1} !== 6'b0) begin
      failures++; $display("FAIL abort_outputs got=%h %b exp=0", {dout_a0, dout_b0, dout_a1, dout_b1},
                           {busy0, done0, coll0, busy1, done1, coll1});
    end
    checks++;
    reset = 1'b0; clr_start = 1'b0; we_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (done0 || done1 || busy0 || busy1) done_cnt++;
      tick();
    end
    if (done_cnt !== 0) begin
      failures++; $display("FAIL abort_no_done got=%0d exp=0", done_cnt);
    end
    checks++;
    for (int i = 0; i < 16; i++) exp_w[i] = 16'h0720;
    exp_w[5] = 16'hAB34;
    exp_w[7] = 16'h2222;
    exp_w[9] = 16'h00FF;
    for (int i = 0; i < 16; i++) begin
      addr_a = 4'(i);
      tick();
      if (dout_a0 !== exp_w[i]) begin
        failures++; $display("FAIL abort_word%0d got=%h exp=%h", i, dout_a0, exp_w[i]);
      end
      checks++;
    end
  endtask

  initial begin
    reset = 1'b1; we_a = 1'b0; be_a = 2'b00; addr_a = '0; din_a = '0;
    addr_b = '0; clr_start = 1'b0;
    test_reset();
    test_clear();
    test_byte_enable();
    test_rdw();
    test_collision();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
